// File: rtl/alu_shift_exec.sv
// alu_shift_exec: execute-stage unit behind the funct7 decoder.
// Add and sub finish in one cycle. Shifts run iteratively, one bit per cycle,
// so no barrel shifter is needed.
//
// Handshake: a request moves on a rising edge where iValid && oReady.
// A result moves on a rising edge where oValid && iResultReady.
// oValid and the result stay stable until the result is accepted.
// oReady is high only in IDLE, so at most one operation is in flight.
// After the result handoff there is always one IDLE cycle before the next accept.
module alu_shift_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [2:1]            iArithmeticType,
  input  logic [2:1]            iRightShiftType,
  input  logic                  iShiftLeft,
  input  logic [DATA_WIDTH-1:0] iOpA,
  input  logic [DATA_WIDTH-1:0] iOpB,
  output logic                  oValid,
  input  logic                  iResultReady,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic                  oIllegal,
  output logic [1:0]            oDbgState
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SK_SLL = 2'd0, SK_SRL = 2'd1, SK_SRA = 2'd2} shift_kind_t;

  state_t                  r_state;
  state_t                  w_state_next;
  shift_kind_t             r_kind;
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [SHAMT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_illegal;

  logic                    w_add, w_sub, w_srl, w_sra, w_sll;
  logic                    w_is_shift, w_legal, w_accept;
  logic [SHAMT_WIDTH-1:0]  w_shamt;
  logic [DATA_WIDTH-1:0]   w_acc_shifted;

  // A request is legal only when exactly one select is active and every other select is zero.
  always_comb begin
    w_add      = (iArithmeticType == 2'b01) && (iRightShiftType == 2'b00) && !iShiftLeft;
    w_sub      = (iArithmeticType == 2'b10) && (iRightShiftType == 2'b00) && !iShiftLeft;
    w_srl      = (iArithmeticType == 2'b00) && (iRightShiftType == 2'b01) && !iShiftLeft;
    w_sra      = (iArithmeticType == 2'b00) && (iRightShiftType == 2'b10) && !iShiftLeft;
    w_sll      = (iArithmeticType == 2'b00) && (iRightShiftType == 2'b00) && iShiftLeft;
    w_is_shift = w_srl || w_sra || w_sll;
    w_legal    = w_add || w_sub || w_is_shift;
    w_shamt    = iOpB[SHAMT_WIDTH-1:0];
    w_accept   = iValid && (r_state == ST_IDLE);
  end

  // Shift the accumulator by one bit in the direction of the latched shift kind.
  always_comb begin
    w_acc_shifted = r_acc;
    case (r_kind)
      SK_SLL:  w_acc_shifted = {r_acc[DATA_WIDTH-2:0], 1'b0};
      SK_SRL:  w_acc_shifted = {1'b0, r_acc[DATA_WIDTH-1:1]};
      SK_SRA:  w_acc_shifted = {r_acc[DATA_WIDTH-1], r_acc[DATA_WIDTH-1:1]};
      default: w_acc_shifted = r_acc;
    endcase
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    oReady       = 1'b0;
    oValid       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        oReady = 1'b1;
        if (w_accept) begin
          if (w_is_shift && (w_shamt != '0)) w_state_next = ST_SHIFT;
          else                               w_state_next = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == SHAMT_WIDTH'(1)) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        oValid = 1'b1;
        if (iResultReady) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate shifts, and clear the illegal flag on handoff.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_kind    <= SK_SLL;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_legal) begin
              r_result  <= '0;
              r_illegal <= 1'b1;
            end else if (w_add) begin
              r_result <= iOpA + iOpB;
            end else if (w_sub) begin
              r_result <= iOpA - iOpB;
            end else if (w_shamt == '0) begin
              r_result <= iOpA;
            end else begin
              r_acc  <= iOpA;
              r_cnt  <= w_shamt;
              r_kind <= w_sll ? SK_SLL : (w_srl ? SK_SRL : SK_SRA);
            end
          end
        end
        ST_SHIFT: begin
          r_acc <= w_acc_shifted;
          r_cnt <= r_cnt - SHAMT_WIDTH'(1);
          if (r_cnt == SHAMT_WIDTH'(1)) r_result <= w_acc_shifted;
        end
        ST_DONE: begin
          if (iResultReady) r_illegal <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign oResult   = r_result;
  assign oIllegal  = r_illegal;
  assign oDbgState = r_state;

endmodule

// File: tb/tb_alu_shift_exec.sv
// tb_alu_shift_exec: runs directed vectors through alu_shift_exec.
// Each expected result is pushed into a queue when its request is issued.
// A monitor pops an entry when a result appears and checks the value, the illegal flag and the latency.
module tb_alu_shift_exec;
  localparam int DW = 32;
  localparam int EW = 8 + 1 + DW;  // {latency, illegal, result}

  // ---------------- clock / reset ----------------
  logic          iClk = 1'b0;
  logic          iRstN;
  logic          iValid;
  logic          oReady;
  logic [2:1]    iArithmeticType;
  logic [2:1]    iRightShiftType;
  logic          iShiftLeft;
  logic [DW-1:0] iOpA;
  logic [DW-1:0] iOpB;
  logic          oValid;
  logic          iResultReady;
  logic [DW-1:0] oResult;
  logic          oIllegal;
  logic [1:0]    oDbgState;

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  alu_shift_exec #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iArithmeticType(iArithmeticType), .iRightShiftType(iRightShiftType),
    .iShiftLeft(iShiftLeft), .iOpA(iOpA), .iOpB(iOpB), .oValid(oValid),
    .iResultReady(iResultReady), .oResult(oResult), .oIllegal(oIllegal),
    .oDbgState(oDbgState)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    iValid          = 1'b0;
    iArithmeticType = 2'b00;
    iRightShiftType = 2'b00;
    iShiftLeft      = 1'b0;
    iOpA            = '0;
    iOpB            = '0;
  endtask

  task automatic issue(input logic [2:1] at, input logic [2:1] rt, input logic sl,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] er, input logic ei, input int lat, input bit push);
    int n;
    n = 0;
    @(negedge iClk);
    iArithmeticType = at;
    iRightShiftType = rt;
    iShiftLeft      = sl;
    iOpA            = a;
    iOpB            = b;
    iValid          = 1'b1;
    while (!oReady && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (!oReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: oReady stayed 0 for %0d cycles, expected 1", n);
      clear_inputs();
      return;
    end
    if (push) begin
      exp_q.push_back({8'(lat), ei, er});
      acc_q.push_back(cyc + 1);
    end
    @(negedge iClk);
    clear_inputs();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((!oReady || exp_q.size() != 0) && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check("wait_idle_ready", 32'(oReady), 32'd1);
  endtask

  // ---------------- monitor ----------------
  logic          prev_valid = 1'b0;
  bit            have_cur   = 1'b0;
  logic [EW-1:0] cur;
  int            acc_at;

  always @(negedge iClk) begin
    if (!iRstN) begin
      prev_valid = 1'b0;
      have_cur   = 1'b0;
    end else begin
      if (oValid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            have_cur = 1'b0;
            $display("FAIL unexpected_result: got 0x%08h with no expected entry", oResult);
          end else begin
            cur      = exp_q.pop_front();
            acc_at   = acc_q.pop_front();
            have_cur = 1'b1;
            check("latency", 32'(cyc - acc_at + 1), 32'(cur[EW-1:EW-8]));
          end
        end
        if (have_cur) begin
          check("result", oResult, cur[DW-1:0]);
          check("illegal", 32'(oIllegal), 32'(cur[DW]));
        end
        check("ready_low_while_valid", 32'(oReady), 32'd0);
      end
      prev_valid = oValid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    clear_inputs();
    iResultReady = 1'b1;
    iRstN        = 1'b0;
    repeat (2) @(negedge iClk);
    check("reset_ready", 32'(oReady), 32'd1);
    check("reset_valid", 32'(oValid), 32'd0);
    check("reset_result", oResult, 32'd0);
    check("reset_illegal", 32'(oIllegal), 32'd0);
    check("reset_state", 32'(oDbgState), 32'd0);
    iRstN = 1'b1;

    // add wraps modulo 2^32
    issue(2'b01, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1'b1);
    // SRA and SRL by 4; upper bits of opB ignored
    issue(2'b00, 2'b10, 1'b0, 32'h8000_00F0, 32'h0000_0104, 32'hF800_000F, 1'b0, 5, 1'b1);
    issue(2'b00, 2'b01, 1'b0, 32'h8000_00F0, 32'h0000_0104, 32'h0800_000F, 1'b0, 5, 1'b1);
    // SLL by 31, with iValid pulsed while shifting
    issue(2'b00, 2'b00, 1'b1, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32, 1'b1);
    repeat (3) @(negedge iClk);
    iArithmeticType = 2'b01;
    iOpA            = 32'h1234_5678;
    iOpB            = 32'h1;
    iValid          = 1'b1;
    check("ready_low_in_shift_a", 32'(oReady), 32'd0);
    @(negedge iClk);
    check("ready_low_in_shift_b", 32'(oReady), 32'd0);
    check("state_shift", 32'(oDbgState), 32'd1);
    clear_inputs();
    // SLL by 0, and SLL by 1 with junk upper opB bits
    issue(2'b00, 2'b00, 1'b1, 32'h1, 32'h0, 32'h1, 1'b0, 1, 1'b1);
    issue(2'b00, 2'b00, 1'b1, 32'h4000_0001, 32'hFFFF_FFE1, 32'h8000_0002, 1'b0, 2, 1'b1);
    // illegal encodings
    issue(2'b11, 2'b00, 1'b0, 32'h5, 32'h6, 32'h0, 1'b1, 1, 1'b1);
    issue(2'b00, 2'b00, 1'b0, 32'h5, 32'h6, 32'h0, 1'b1, 1, 1'b1);
    issue(2'b01, 2'b00, 1'b1, 32'h5, 32'h6, 32'h0, 1'b1, 1, 1'b1);
    issue(2'b00, 2'b11, 1'b0, 32'h5, 32'h6, 32'h0, 1'b1, 1, 1'b1);
    // legal add after an illegal request: the illegal flag must clear
    issue(2'b01, 2'b00, 1'b0, 32'h10, 32'h20, 32'h30, 1'b0, 1, 1'b1);

    // sub with the consumer stalling for 4 cycles
    wait_idle();
    iResultReady = 1'b0;
    issue(2'b10, 2'b00, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 1'b1);
    repeat (3) @(negedge iClk);
    check("stall_valid_held", 32'(oValid), 32'd1);
    iResultReady = 1'b1;
    @(negedge iClk);
    check("handoff_valid_low", 32'(oValid), 32'd0);
    check("handoff_ready_high", 32'(oReady), 32'd1);
    check("handoff_result_held", oResult, 32'hFFFF_FFFE);

    // reset in the middle of an SRL by 20
    wait_idle();
    issue(2'b00, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd20, 32'h0, 1'b0, 21, 1'b0);
    repeat (5) @(negedge iClk);
    iRstN = 1'b0;
    #1;
    check("midreset_valid", 32'(oValid), 32'd0);
    check("midreset_result", oResult, 32'd0);
    check("midreset_ready", 32'(oReady), 32'd1);
    check("midreset_state", 32'(oDbgState), 32'd0);
    @(negedge iClk);
    iRstN = 1'b1;
    issue(2'b01, 2'b00, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b1);

    // drain
    n = 0;
    while ((exp_q.size() != 0 || !oReady) && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge iClk);
    check("no_stray_valid", 32'(oValid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_shift_exec.md
Name: alu_shift_exec

Overview:
- Execute-stage unit directly downstream of the funct7 decoder.
- Consumes the decoder's one-hot add/sub select and right-shift-type select, plus a left-shift strobe, and produces a registered 32-bit result.
- Add/sub completes in one cycle. Shifts are iterative, 1 bit per cycle, to avoid a barrel shifter.
- Uses a valid/ready handshake on both input and output so the control unit can stall on it.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from iOpB[SHAMT_WIDTH-1:0]; must equal log2(DATA_WIDTH).

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iValid  input  1  operation request valid.
- oReady  output  1  unit can accept a request; equals (state==IDLE).
- iArithmeticType  input  [2:1]  one-hot {sub,add} from the funct7 decoder.
- iRightShiftType  input  [2:1]  one-hot {arithmetic,logical} from the funct7 decoder.
- iShiftLeft  input  1  logical left shift request.
- iOpA  input  DATA_WIDTH  operand A, or the value being shifted.
- iOpB  input  DATA_WIDTH  operand B; shift amount = iOpB[SHAMT_WIDTH-1:0].
- oValid  output  1  result valid; held until accepted.
- iResultReady  input  1  consumer accepts the result.
- oResult  output  DATA_WIDTH  registered result.
- oIllegal  output  1  qualifies oValid: the request had an illegal select encoding.

Behaviour:
- Reset (async, iRstN low): state=IDLE, oValid=0, oResult=0, oIllegal=0, shift counter=0, accumulator=0.
  - oReady reads 1 while in reset, because state is IDLE.
  - Reset during SHIFT or DONE aborts the operation immediately; no result is produced.
- Legal request: exactly one of these selects is active:
  - iArithmeticType == 2'b01 (add) or 2'b10 (sub), other selects zero;
  - iRightShiftType == 2'b01 (SRL) or 2'b10 (SRA), other selects zero;
  - iShiftLeft == 1, other selects zero.
  - Any other combination is illegal, including all-zero and 2'b11 on either vector.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Accept on the rising edge where iValid && oReady. Inputs are sampled only on that edge and ignored otherwise.
  - add/sub: oResult <= iOpA +/- iOpB, modulo 2^DATA_WIDTH (sub is two's complement). Go to DONE.
  - shift, shamt==0: oResult <= iOpA. Go to DONE.
  - shift, shamt!=0: accumulator <= iOpA, counter <= shamt, latch the shift kind. Go to SHIFT.
  - illegal: oResult <= 0, oIllegal <= 1. Go to DONE.
- SHIFT, once per cycle:
  - accumulator shifts 1 bit: SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates bit DATA_WIDTH-1.
  - counter decrements.
  - On the cycle the counter goes 1->0: oResult <= the shifted value, go to DONE.
  - iValid is ignored (oReady=0).
- DONE:
  - oValid=1; oResult and oIllegal are stable.
  - On an edge with iResultReady=1: go to IDLE and clear oValid and oIllegal. oResult holds its last value.
  - No new accept happens in the same cycle; oReady rises the cycle after the handoff.
  - iResultReady outside DONE is ignored.
- Latency, from the accept edge to the first cycle oValid=1:
  - 1 cycle for add/sub, shift by 0, and illegal requests.
  - 1+shamt cycles for a shift by shamt (max 32 for DATA_WIDTH=32).
- Throughput: one operation in flight; the next accept happens no earlier than 1 cycle after result handoff.
- Upper bits iOpB[DATA_WIDTH-1:SHAMT_WIDTH] are ignored for shifts.

Test Plan:
- Add: iOpA=0xFFFF_FFFF, iOpB=1, iArithmeticType=01 -> oValid one cycle after accept, oResult=0x0000_0000, oIllegal=0.
- Sub then stall: iOpA=5, iOpB=7, iArithmeticType=10, iResultReady held 0 for 4 cycles -> oResult=0xFFFF_FFFE; oValid and oResult stable throughout; oReady=0 until the cycle after iResultReady=1.
- SRA/SRL by 4: iOpA=0x8000_00F0, iOpB=0x0000_0104, iRightShiftType=10 -> oValid 5 cycles after accept, oResult=0xF800_000F. Repeat with iRightShiftType=01 -> oResult=0x0800_000F.
- SLL edges: iOpA=1, iShiftLeft=1.
  - shamt=31 -> oResult=0x8000_0000 after 32 cycles.
  - shamt=0 -> oResult=1 after 1 cycle.
  - iValid pulsed during SHIFT -> ignored, oReady=0.
- Illegal encodings: iArithmeticType=11; all selects zero; iShiftLeft=1 with iArithmeticType=01 -> each gives oValid after 1 cycle, oIllegal=1, oResult=0.
- Reset mid-shift: start SRL by 20, drop iRstN at cycle 7 -> oValid=0, oResult=0 immediately and oReady=1. After release, an add of 2+3 -> oResult=5.
